// File: rtl/trigger_pkg.sv
// Shared definitions for the analog trigger bar path: sample width,
// default frame timing constants, sequencer states and the deadzone rule.
package trigger_pkg;

    localparam int TRIG_W = 8;
    localparam int Y_W    = 10;

    // Defaults shared with the trigger bar drawer
    localparam int V_VISIBLE_DEF      = 480;
    localparam int DEADZONE_DEF       = 8;
    localparam int HOLD_FRAMES_DEF    = 30;
    localparam int DECAY_STEP_DEF     = 4;
    localparam int TIMEOUT_FRAMES_DEF = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        PEAK   = 2'd2
    } seq_state_e;

    // Samples strictly below the threshold read as zero; others pass unchanged
    function automatic logic [TRIG_W-1:0] apply_deadzone(
        input logic [TRIG_W-1:0] raw,
        input logic [TRIG_W-1:0] threshold
    );
        return (raw < threshold) ? '0 : raw;
    endfunction

endpackage

// File: rtl/trigger_peak_hold.sv
// Peak-hold marker for one trigger channel: a new peak is held for
// HOLD_FRAMES updates, then decays by DECAY_STEP per update down to disp.
module trigger_peak_hold
    import trigger_pkg::*;
#(
    parameter int HOLD_FRAMES = HOLD_FRAMES_DEF,
    parameter int DECAY_STEP  = DECAY_STEP_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              upd_i,
    input  logic [TRIG_W-1:0] disp_i,
    output logic [TRIG_W-1:0] peak_o
);

    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
    localparam int EXT_W  = TRIG_W + 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_FRAMES);
    localparam logic [EXT_W-1:0]  STEP_EXT  = EXT_W'(DECAY_STEP);

    logic [TRIG_W-1:0] peak_q, peak_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [EXT_W-1:0]  dec_w;

    // Next peak/hold: capture a higher disp, else count down the hold, else decay
    always_comb begin
        peak_d = peak_q;
        hold_d = hold_q;
        // One extra bit so a decay below zero shows up as a set MSB, not a wrap
        dec_w  = {1'b0, peak_q} - STEP_EXT;
        if (upd_i) begin
            if (disp_i > peak_q) begin
                peak_d = disp_i;
                hold_d = HOLD_LOAD;
            end else if (hold_q != '0) begin
                hold_d = hold_q - HOLD_W'(1);
            end else if (dec_w[EXT_W-1] || (dec_w[TRIG_W-1:0] < disp_i)) begin
                peak_d = disp_i;
            end else begin
                peak_d = dec_w[TRIG_W-1:0];
            end
        end
    end

    // Peak and hold registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q <= '0;
            hold_q <= '0;
        end else begin
            peak_q <= peak_d;
            hold_q <= hold_d;
        end
    end

    assign peak_o = peak_q;

endmodule

// File: rtl/analog_trigger_sequencer.sv
// Frame-synchronous trigger bar controller: captures deadzoned samples into
// shadow registers, commits them to the display registers at the start of
// vertical blank, tracks data staleness and drives per-channel peak markers.
module analog_trigger_sequencer
    import trigger_pkg::*;
#(
    parameter int V_VISIBLE      = V_VISIBLE_DEF,
    parameter int DEADZONE       = DEADZONE_DEF,
    parameter int HOLD_FRAMES    = HOLD_FRAMES_DEF,
    parameter int DECAY_STEP     = DECAY_STEP_DEF,
    parameter int TIMEOUT_FRAMES = TIMEOUT_FRAMES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [Y_W-1:0]    y,
    input  logic              trig_valid,
    input  logic [TRIG_W-1:0] l_trigger_raw,
    input  logic [TRIG_W-1:0] r_trigger_raw,
    output logic [TRIG_W-1:0] l_trigger_disp,
    output logic [TRIG_W-1:0] r_trigger_disp,
    output logic [TRIG_W-1:0] l_peak,
    output logic [TRIG_W-1:0] r_peak,
    output logic              stale,
    output logic              frame_commit
);

    localparam int CNT_W = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(TIMEOUT_FRAMES);
    localparam logic [Y_W-1:0]    VBLANK_Y    = Y_W'(V_VISIBLE);
    localparam logic [TRIG_W-1:0] DZ_LEVEL    = TRIG_W'(DEADZONE);

    logic              vb_now;
    logic              vblank_rise;
    logic              prev_vb_q, prev_vb_d;
    logic [TRIG_W-1:0] shadow_l_q, shadow_l_d;
    logic [TRIG_W-1:0] shadow_r_q, shadow_r_d;
    logic [CNT_W-1:0]  stale_cnt_q, stale_cnt_d;
    seq_state_e        state_q, state_d;
    logic [TRIG_W-1:0] disp_l_q, disp_l_d;
    logic [TRIG_W-1:0] disp_r_q, disp_r_d;
    logic              stale_q, stale_d;
    logic              frame_commit_q, frame_commit_d;
    logic              peak_upd;

    assign vb_now      = (y >= VBLANK_Y);
    assign vblank_rise = vb_now && !prev_vb_q;

    // Capture path and stale counter; a valid sample always clears the count
    always_comb begin
        prev_vb_d   = vb_now;
        shadow_l_d  = shadow_l_q;
        shadow_r_d  = shadow_r_q;
        stale_cnt_d = stale_cnt_q;
        if (trig_valid) begin
            shadow_l_d  = apply_deadzone(l_trigger_raw, DZ_LEVEL);
            shadow_r_d  = apply_deadzone(r_trigger_raw, DZ_LEVEL);
            stale_cnt_d = '0;
        end else if (vblank_rise && (stale_cnt_q != TIMEOUT_CNT)) begin
            stale_cnt_d = stale_cnt_q + CNT_W'(1);
        end
    end

    // Sequencer next state: commit on the vblank edge, then update peaks
    always_comb begin
        state_d        = state_q;
        disp_l_d       = disp_l_q;
        disp_r_d       = disp_r_q;
        stale_d        = stale_q;
        frame_commit_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (vblank_rise) begin
                    state_d        = COMMIT;
                    frame_commit_d = 1'b1;
                end
            end
            COMMIT: begin
                state_d = PEAK;
                if (stale_cnt_q == TIMEOUT_CNT) begin
                    disp_l_d = '0;
                    disp_r_d = '0;
                    stale_d  = 1'b1;
                end else begin
                    disp_l_d = shadow_l_q;
                    disp_r_d = shadow_r_q;
                    stale_d  = 1'b0;
                end
            end
            PEAK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; prev_vb resets high so a release in vblank is quiet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_vb_q      <= 1'b1;
            shadow_l_q     <= '0;
            shadow_r_q     <= '0;
            stale_cnt_q    <= TIMEOUT_CNT;
            state_q        <= IDLE;
            disp_l_q       <= '0;
            disp_r_q       <= '0;
            stale_q        <= 1'b1;
            frame_commit_q <= 1'b0;
        end else begin
            prev_vb_q      <= prev_vb_d;
            shadow_l_q     <= shadow_l_d;
            shadow_r_q     <= shadow_r_d;
            stale_cnt_q    <= stale_cnt_d;
            state_q        <= state_d;
            disp_l_q       <= disp_l_d;
            disp_r_q       <= disp_r_d;
            stale_q        <= stale_d;
            frame_commit_q <= frame_commit_d;
        end
    end

    assign peak_upd = (state_q == PEAK);

    trigger_peak_hold #(
        .HOLD_FRAMES (HOLD_FRAMES),
        .DECAY_STEP  (DECAY_STEP)
    ) u_peak_l (
        .clk    (clk),
        .rst_n  (rst_n),
        .upd_i  (peak_upd),
        .disp_i (disp_l_q),
        .peak_o (l_peak)
    );

    trigger_peak_hold #(
        .HOLD_FRAMES (HOLD_FRAMES),
        .DECAY_STEP  (DECAY_STEP)
    ) u_peak_r (
        .clk    (clk),
        .rst_n  (rst_n),
        .upd_i  (peak_upd),
        .disp_i (disp_r_q),
        .peak_o (r_peak)
    );

    assign l_trigger_disp = disp_l_q;
    assign r_trigger_disp = disp_r_q;
    assign stale          = stale_q;
    assign frame_commit   = frame_commit_q;

endmodule

// File: tb/tb_analog_trigger_sequencer.sv
// Bench for analog_trigger_sequencer: cycle vector table, directed
// multi-frame sequences and a randomized run against a frame-level model.
module tb_analog_trigger_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] y;
    logic       trig_valid;
    logic [7:0] l_trigger_raw, r_trigger_raw;
    logic [7:0] l_trigger_disp, r_trigger_disp;
    logic [7:0] l_peak, r_peak;
    logic       stale, frame_commit;

    int n_checks = 0;
    int n_errors = 0;

    analog_trigger_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .y              (y),
        .trig_valid     (trig_valid),
        .l_trigger_raw  (l_trigger_raw),
        .r_trigger_raw  (r_trigger_raw),
        .l_trigger_disp (l_trigger_disp),
        .r_trigger_disp (r_trigger_disp),
        .l_peak         (l_peak),
        .r_peak         (r_peak),
        .stale          (stale),
        .frame_commit   (frame_commit)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         yy;
        logic       v;
        logic [7:0] l;
        logic [7:0] r;
        logic [7:0] e_dl;
        logic [7:0] e_dr;
        logic [7:0] e_pl;
        logic [7:0] e_pr;
        logic       e_st;
        logic       e_fc;
    } vec_t;

    vec_t tbl [11];

    // Frame-level reference state
    int m_sh_l, m_sh_r, m_cnt, m_dl, m_dr, m_st, m_pl, m_pr, m_hl, m_hr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int yy, input logic v, input logic [7:0] l, input logic [7:0] r);
        y             = 10'(yy);
        trig_valid    = v;
        l_trigger_raw = l;
        r_trigger_raw = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        y             = 10'd0;
        trig_valid    = 1'b0;
        l_trigger_raw = 8'h00;
        r_trigger_raw = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".disp_l"}, l_trigger_disp, 0);
        chk({tag, ".disp_r"}, r_trigger_disp, 0);
        chk({tag, ".peak_l"}, l_peak, 0);
        chk({tag, ".peak_r"}, r_peak, 0);
        chk({tag, ".stale"}, stale, 1);
        chk({tag, ".commit"}, frame_commit, 0);
    endtask

    // One frame: optional sample in the visible area, then three vblank lines
    task automatic frame(input logic v, input logic [7:0] l, input logic [7:0] r);
        step(100, v, l, r);
        step(100, 1'b0, 8'h00, 8'h00);
        step(480, 1'b0, 8'h00, 8'h00);
        step(480, 1'b0, 8'h00, 8'h00);
        step(480, 1'b0, 8'h00, 8'h00);
    endtask

    function automatic int dz(input int x);
        return (x < 8) ? 0 : x;
    endfunction

    function automatic int exp_decay(input int start, input int floor_v, input int k);
        int p;
        if (k <= 30) return start;
        p = start - 4 * (k - 30);
        return (p < floor_v) ? floor_v : p;
    endfunction

    task automatic m_sample(input int l, input int r);
        m_sh_l = dz(l);
        m_sh_r = dz(r);
        m_cnt  = 0;
    endtask

    task automatic m_peak(inout int pk, inout int hd, input int d);
        if (d > pk) begin
            pk = d;
            hd = 30;
        end else if (hd > 0) begin
            hd = hd - 1;
        end else begin
            pk = pk - 4;
            if (pk < d) pk = d;
        end
    endtask

    // What the display shows once this frame's vblank has begun
    task automatic m_commit();
        if (m_cnt >= 15) begin
            m_dl = 0;
            m_dr = 0;
            m_st = 1;
        end else begin
            m_dl = m_sh_l;
            m_dr = m_sh_r;
            m_st = 0;
        end
        m_peak(m_pl, m_hl, m_dl);
        m_peak(m_pr, m_hr, m_dr);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rl, rr;
        logic       rv;
        int         vy;

        tbl[0]  = '{100, 1'b1, 8'h05, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[1]  = '{479, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[2]  = '{480, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1};
        tbl[3]  = '{480, 1'b0, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[4]  = '{480, 1'b0, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h80, 1'b0, 1'b0};
        tbl[5]  = '{200, 1'b1, 8'h40, 8'h80, 8'h00, 8'h80, 8'h00, 8'h80, 1'b0, 1'b0};
        tbl[6]  = '{200, 1'b1, 8'h90, 8'h80, 8'h00, 8'h80, 8'h00, 8'h80, 1'b0, 1'b0};
        tbl[7]  = '{300, 1'b0, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h80, 1'b0, 1'b0};
        tbl[8]  = '{480, 1'b0, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h80, 1'b0, 1'b1};
        tbl[9]  = '{480, 1'b0, 8'h00, 8'h00, 8'h90, 8'h80, 8'h00, 8'h80, 1'b0, 1'b0};
        tbl[10] = '{481, 1'b0, 8'h00, 8'h00, 8'h90, 8'h80, 8'h90, 8'h80, 1'b0, 1'b0};

        // Reset values, then deadzone/commit and no-tearing vectors
        do_reset();
        chk_reset("rst");
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].yy, tbl[i].v, tbl[i].l, tbl[i].r);
            chk($sformatf("vec%0d.disp_l", i), l_trigger_disp, tbl[i].e_dl);
            chk($sformatf("vec%0d.disp_r", i), r_trigger_disp, tbl[i].e_dr);
            chk($sformatf("vec%0d.peak_l", i), l_peak, tbl[i].e_pl);
            chk($sformatf("vec%0d.peak_r", i), r_peak, tbl[i].e_pr);
            chk($sformatf("vec%0d.stale", i), stale, tbl[i].e_st);
            chk($sformatf("vec%0d.commit", i), frame_commit, tbl[i].e_fc);
        end

        // Peak hold then decay to the committed floor
        do_reset();
        frame(1'b1, 8'hC8, 8'h00);
        chk("hold.start", l_peak, 8'hC8);
        for (int k = 1; k <= 80; k++) begin
            frame(1'b1, 8'h10, 8'h00);
            chk($sformatf("hold.k%0d", k), l_peak, exp_decay(200, 16, k));
        end
        chk("hold.disp", l_trigger_disp, 8'h10);

        // Decay toward zero must clamp, never wrap
        do_reset();
        frame(1'b1, 8'h0C, 8'h00);
        chk("wrap.start", l_peak, 8'h0C);
        for (int k = 1; k <= 34; k++) begin
            frame(1'b1, 8'h03, 8'h00);
            chk($sformatf("wrap.k%0d", k), l_peak, exp_decay(12, 0, k));
        end
        chk("wrap.disp_dz", l_trigger_disp, 8'h00);

        // Stale timeout and recovery
        do_reset();
        frame(1'b1, 8'h33, 8'h44);
        chk("stale.first_l", l_trigger_disp, 8'h33);
        chk("stale.first_st", stale, 0);
        for (int j = 1; j <= 14; j++) begin
            frame(1'b0, 8'h00, 8'h00);
            chk($sformatf("stale.j%0d.disp_l", j), l_trigger_disp, (j == 14) ? 0 : 8'h33);
            chk($sformatf("stale.j%0d.disp_r", j), r_trigger_disp, (j == 14) ? 0 : 8'h44);
            chk($sformatf("stale.j%0d.st", j), stale, (j == 14) ? 1 : 0);
        end
        frame(1'b1, 8'h55, 8'h66);
        chk("stale.recover_l", l_trigger_disp, 8'h55);
        chk("stale.recover_r", r_trigger_disp, 8'h66);
        chk("stale.recover_st", stale, 0);

        // Valid coinciding with the rise, then valid on the commit edge
        do_reset();
        frame(1'b1, 8'h20, 8'h00);
        step(100, 1'b0, 8'h00, 8'h00);
        step(480, 1'b1, 8'h50, 8'h00);
        chk("sim.commit", frame_commit, 1);
        step(480, 1'b0, 8'h00, 8'h00);
        chk("sim.disp", l_trigger_disp, 8'h50);
        chk("sim.st", stale, 0);
        step(480, 1'b0, 8'h00, 8'h00);
        step(100, 1'b1, 8'h30, 8'h00);
        step(480, 1'b0, 8'h00, 8'h00);
        chk("late.commit", frame_commit, 1);
        step(480, 1'b1, 8'h60, 8'h00);
        chk("late.disp_old", l_trigger_disp, 8'h30);
        chk("late.commit_low", frame_commit, 0);
        step(480, 1'b0, 8'h00, 8'h00);
        frame(1'b0, 8'h00, 8'h00);
        chk("late.disp_next", l_trigger_disp, 8'h60);
        chk("late.st", stale, 0);

        // Reset asserted in the PEAK state while in vblank
        do_reset();
        frame(1'b1, 8'h70, 8'h70);
        step(100, 1'b0, 8'h00, 8'h00);
        step(481, 1'b0, 8'h00, 8'h00);
        chk("mid.commit", frame_commit, 1);
        step(481, 1'b0, 8'h00, 8'h00);
        chk("mid.disp", l_trigger_disp, 8'h70);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("mid.async");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(481, 1'b0, 8'h00, 8'h00);
            chk($sformatf("mid.quiet%0d", i), frame_commit, 0);
            chk($sformatf("mid.quiet%0d.st", i), stale, 1);
        end
        step(470, 1'b0, 8'h00, 8'h00);
        chk("mid.visible", frame_commit, 0);
        step(480, 1'b0, 8'h00, 8'h00);
        chk("mid.rise", frame_commit, 1);
        step(480, 1'b0, 8'h00, 8'h00);
        chk("mid.stale_disp", l_trigger_disp, 0);
        chk("mid.stale_st", stale, 1);

        // Randomized frames against the frame-level model
        do_reset();
        m_sh_l = 0; m_sh_r = 0; m_cnt = 15; m_dl = 0; m_dr = 0; m_st = 1;
        m_pl = 0; m_pr = 0; m_hl = 0; m_hr = 0;
        for (int f = 0; f < 200; f++) begin
            bit allow;
            int nvis;
            allow = (f % 40) < 22;
            nvis  = $urandom_range(1, 5);
            for (int i = 0; i < nvis; i++) begin
                rv = allow && ($urandom_range(0, 2) == 0);
                rl = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
                rr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
                step(int'($urandom_range(0, 479)), rv, rl, rr);
                if (rv) m_sample(rl, rr);
            end
            chk($sformatf("rnd%0d.vis_disp_l", f), l_trigger_disp, m_dl);
            chk($sformatf("rnd%0d.vis_commit", f), frame_commit, 0);

            vy = 480 + int'($urandom_range(0, 44));
            rv = allow && ($urandom_range(0, 3) == 0);
            rl = 8'($urandom_range(0, 255));
            rr = 8'($urandom_range(0, 255));
            step(vy, rv, rl, rr);
            if (rv) m_sample(rl, rr);
            else if (m_cnt < 15) m_cnt++;
            m_commit();
            chk($sformatf("rnd%0d.commit", f), frame_commit, 1);

            rv = allow && ($urandom_range(0, 3) == 0);
            rl = 8'($urandom_range(0, 255));
            rr = 8'($urandom_range(0, 255));
            step(vy, rv, rl, rr);
            if (rv) m_sample(rl, rr);
            chk($sformatf("rnd%0d.disp_l", f), l_trigger_disp, m_dl);
            chk($sformatf("rnd%0d.disp_r", f), r_trigger_disp, m_dr);
            chk($sformatf("rnd%0d.stale", f), stale, m_st);
            chk($sformatf("rnd%0d.commit_low", f), frame_commit, 0);

            rv = allow && ($urandom_range(0, 3) == 0);
            rl = 8'($urandom_range(0, 255));
            rr = 8'($urandom_range(0, 255));
            step(vy, rv, rl, rr);
            if (rv) m_sample(rl, rr);
            chk($sformatf("rnd%0d.peak_l", f), l_peak, m_pl);
            chk($sformatf("rnd%0d.peak_r", f), r_peak, m_pr);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
